// File: rtl/tt_slot_pkg.sv
// rtl/tt_slot_pkg.sv - shared widths, FSM states and iw field offsets for the slot controller
package tt_slot_pkg;

    localparam int IW_W   = 18;
    localparam int OW_W   = 24;
    localparam int GCNT_W = 4;

    localparam int IW_CLK     = 0;
    localparam int IW_RST_N   = 1;
    localparam int IW_UI_LSB  = 2;
    localparam int IW_UIO_LSB = 10;

    typedef enum logic [1:0] {
        IDLE,
        GUARD,
        ACTIVE
    } slot_state_e;

endpackage

// File: rtl/tt_slot_ctrl_if.sv
// rtl/tt_slot_ctrl_if.sv - per-slot iw/ena/ow bundle between controller and project wrappers
interface tt_slot_ctrl_if #(
    parameter int N_SLOTS = 24
);
    import tt_slot_pkg::*;

    logic [N_SLOTS*IW_W-1:0] slot_iw;
    logic [N_SLOTS-1:0]      slot_ena;
    logic [N_SLOTS*OW_W-1:0] slot_ow;

    modport master (output slot_iw, output slot_ena, input slot_ow);
    modport slave  (input slot_iw, input slot_ena, output slot_ow);

endinterface

// File: rtl/tt_sync.sv
// rtl/tt_sync.sv - multi-flop synchroniser for an asynchronous pad input
module tt_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], d_i};
        end
    end

    assign q_o = r_chain[STAGES-1];

endmodule

// File: rtl/tt_slot_ctrl.sv
// rtl/tt_slot_ctrl.sv - tile slot controller: address counter, guarded enable FSM, iw fan-out, ow return
module tt_slot_ctrl
    import tt_slot_pkg::*;
#(
    parameter int N_SLOTS     = 24,
    parameter int ADDR_W      = 5,
    parameter int SYNC_STAGES = 2,
    parameter int GUARD_CYC   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sel_rst_n_i,
    input  logic              sel_inc_i,
    input  logic              ena_i,
    input  logic [IW_W-1:0]   pad_iw,
    tt_slot_ctrl_if.master    slots,
    output logic [OW_W-1:0]   pad_ow,
    output logic [ADDR_W-1:0] cur_addr,
    output logic              slot_active
);

    localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;
    localparam logic [GCNT_W-1:0] GCNT_LOAD = GCNT_W'(GUARD_CYC - 1);

    logic w_srst_n, w_sinc, w_sena;

    tt_sync #(.STAGES(SYNC_STAGES)) u_sync_rst (.clk(clk), .rst_n(rst_n), .d_i(sel_rst_n_i), .q_o(w_srst_n));
    tt_sync #(.STAGES(SYNC_STAGES)) u_sync_inc (.clk(clk), .rst_n(rst_n), .d_i(sel_inc_i),   .q_o(w_sinc));
    tt_sync #(.STAGES(SYNC_STAGES)) u_sync_ena (.clk(clk), .rst_n(rst_n), .d_i(ena_i),       .q_o(w_sena));

    slot_state_e         r_state;
    logic [GCNT_W-1:0]   r_gcnt;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_sinc_d;
    logic                r_active;
    logic [N_SLOTS-1:0]  r_ena;
    logic [OW_W-1:0]     r_pad_ow;

    logic                w_inc_edge;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic                w_addr_chg;
    logic                w_addr_ok;
    logic                w_run;
    logic                w_keep;
    logic [N_SLOTS-1:0]  w_onehot;
    logic [OW_W-1:0]     w_ow_arr [N_SLOTS];
    logic [OW_W-1:0]     w_ow_sel;

    assign w_inc_edge = w_sinc & ~r_sinc_d;

    // Select reset beats a simultaneous increment; the counter saturates instead of wrapping.
    always_comb begin
        w_addr_nxt = r_addr;
        if (!w_srst_n) begin
            w_addr_nxt = '0;
        end else if (w_inc_edge && (r_addr != ADDR_MAX)) begin
            w_addr_nxt = r_addr + ADDR_W'(1);
        end
    end

    assign w_addr_chg = (w_addr_nxt != r_addr);
    assign w_addr_ok  = (int'(r_addr) < N_SLOTS);
    assign w_run      = w_sena & w_srst_n & w_addr_ok;
    // Drop the enable in the same edge the abort or address change is seen, never one slot late.
    assign w_keep     = (r_state == ACTIVE) & w_run & ~w_addr_chg;
    assign w_onehot   = N_SLOTS'(1) << r_addr;
    assign w_ow_sel   = w_addr_ok ? w_ow_arr[r_addr] : '0;

    for (genvar k = 0; k < N_SLOTS; k++) begin : g_slot
        assign w_ow_arr[k] = slots.slot_ow[k*OW_W +: OW_W];
        assign slots.slot_iw[k*IW_W +: IW_W] = r_ena[k] ? pad_iw : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_gcnt   <= '0;
            r_addr   <= '0;
            r_sinc_d <= 1'b0;
            r_active <= 1'b0;
            r_ena    <= '0;
            r_pad_ow <= '0;
        end else begin
            r_sinc_d <= w_sinc;
            r_addr   <= w_addr_nxt;
            r_active <= w_keep;
            r_ena    <= w_keep ? w_onehot : '0;
            r_pad_ow <= r_active ? w_ow_sel : '0;
            case (r_state)
                IDLE: begin
                    if (w_run) begin
                        r_state <= GUARD;
                        r_gcnt  <= GCNT_LOAD;
                    end
                end
                GUARD: begin
                    if (!w_run) begin
                        r_state <= IDLE;
                    end else if (w_addr_chg) begin
                        r_gcnt <= GCNT_LOAD;
                    end else if (r_gcnt == '0) begin
                        r_state <= ACTIVE;
                    end else begin
                        r_gcnt <= r_gcnt - GCNT_W'(1);
                    end
                end
                ACTIVE: begin
                    if (!w_run) begin
                        r_state <= IDLE;
                    end else if (w_addr_chg) begin
                        r_state <= GUARD;
                        r_gcnt  <= GCNT_LOAD;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign slots.slot_ena = r_ena;
    assign pad_ow         = r_pad_ow;
    assign cur_addr       = r_addr;
    assign slot_active    = r_active;

endmodule
